// File: rtl/int_sequencer_pkg.sv
// Shared types and vector constants for the 6502 interrupt sequencer.
package core6502_int_pkg;
  typedef enum logic [2:0] {CLS_NONE, CLS_RES, CLS_NMI, CLS_IRQ, CLS_BRK} int_cls_e;
  typedef enum logic [1:0] {IDLE, REQ, SEQ} int_state_e;

  localparam logic [15:0] VEC_NMI = 16'hFFFA;
  localparam logic [15:0] VEC_RES = 16'hFFFC;
  localparam logic [15:0] VEC_IRQ = 16'hFFFE;
endpackage

// File: rtl/int_sequencer_if.sv
// Pad/core-side signal bundle of the interrupt sequencer; slave = sequencer, master = core/pads.
interface int_sequencer_if #(
  parameter int N_IRQ = 4
);
  localparam int IW = (N_IRQ > 1) ? $clog2(N_IRQ) : 1;

  logic             n_NMI;
  logic [N_IRQ-1:0] n_IRQ;
  logic [N_IRQ-1:0] IRQ_EN;
  logic             I_FLAG;
  logic             T0;
  logic             BRK_OP;
  logic             INT_ACK;
  logic             VEC_DONE;
  logic             INT_REQ;
  logic             DORES;
  logic             n_DONMI;
  logic             B_OUT;
  logic [15:0]      VEC_ADDR;
  logic [IW-1:0]    IRQ_ID;
  logic             BUSY;

  modport slave (
    input  n_NMI, n_IRQ, IRQ_EN, I_FLAG, T0, BRK_OP, INT_ACK, VEC_DONE,
    output INT_REQ, DORES, n_DONMI, B_OUT, VEC_ADDR, IRQ_ID, BUSY
  );

  modport master (
    output n_NMI, n_IRQ, IRQ_EN, I_FLAG, T0, BRK_OP, INT_ACK, VEC_DONE,
    input  INT_REQ, DORES, n_DONMI, B_OUT, VEC_ADDR, IRQ_ID, BUSY
  );
endinterface

// File: rtl/int_sequencer_sync.sv
// Multi-flop synchroniser for active-low pad inputs; resets to all ones (inactive).
module int_sync #(
  parameter int W      = 1,
  parameter int STAGES = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] i_d,
  output logic [W-1:0] o_q
);
  logic [W-1:0] r_stg [STAGES];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < STAGES; i++) r_stg[i] <= '1;
    end else begin
      r_stg[0] <= i_d;
      for (int i = 1; i < STAGES; i++) r_stg[i] <= r_stg[i-1];
    end
  end

  assign o_q = r_stg[STAGES-1];
endmodule

// File: rtl/int_sequencer.sv
// Interrupt sequencer: RES > NMI > IRQ > BRK arbitration, vector and qualifier generation.
// Optional macro INT_SEQ_VECTORED_IRQ_EN gives each IRQ source its own vector at IRQ_VEC_BASE + 2*id.
module int_sequencer
  import core6502_int_pkg::*;
#(
  parameter int          N_IRQ        = 4,
  parameter int          SYNC_STAGES  = 2,
  parameter logic [15:0] IRQ_VEC_BASE = 16'hFFE0
) (
  input  logic            PHI0,
  input  logic            RES,
  int_sequencer_if.slave  bus
);
  localparam int IW = (N_IRQ > 1) ? $clog2(N_IRQ) : 1;

  logic             w_nmi_s;
  logic [N_IRQ-1:0] w_irq_s;
  logic [N_IRQ-1:0] w_irq_act;
  logic             w_irq_ok;
  logic             w_nmi_fall;
  logic             w_any;
  logic [IW-1:0]    w_irq_idx;
  logic [15:0]      w_irq_vec;

  int_state_e    r_state, w_state_nx;
  int_cls_e      w_cls;
  logic          r_nmi_prev, r_nmi_pend, r_res_pend;
  logic          r_dores, r_n_donmi, r_b_out;
  logic [15:0]   r_vec;
  logic [IW-1:0] r_id;
  logic          w_dores_nx, w_n_donmi_nx, w_b_out_nx;
  logic [15:0]   w_vec_nx;
  logic [IW-1:0] w_id_nx;
  logic          w_latch, w_clr_res, w_clr_nmi;

  int_sync #(.W(1), .STAGES(SYNC_STAGES)) u_nmi_sync (
    .clk(PHI0), .rst(RES), .i_d(bus.n_NMI), .o_q(w_nmi_s)
  );

  int_sync #(.W(N_IRQ), .STAGES(SYNC_STAGES)) u_irq_sync (
    .clk(PHI0), .rst(RES), .i_d(bus.n_IRQ), .o_q(w_irq_s)
  );

  assign w_irq_act  = ~w_irq_s & bus.IRQ_EN;
  assign w_irq_ok   = (|w_irq_act) & ~bus.I_FLAG;
  assign w_nmi_fall = r_nmi_prev & ~w_nmi_s;
  assign w_any      = r_res_pend | r_nmi_pend | w_irq_ok;

  always_comb begin
    w_irq_idx = '0;
    for (int i = N_IRQ - 1; i >= 0; i--) begin
      if (w_irq_act[i]) w_irq_idx = IW'(i);
    end
  end

`ifdef INT_SEQ_VECTORED_IRQ_EN
  assign w_irq_vec = IRQ_VEC_BASE + (16'(w_irq_idx) << 1);
`else
  // Shared-vector build: the base is masked off so every IRQ lands on FFFE.
  assign w_irq_vec = VEC_IRQ | (IRQ_VEC_BASE & 16'h0000) | (16'(w_irq_idx) & 16'h0000);
`endif

  always_comb begin
    w_state_nx   = r_state;
    w_dores_nx   = r_dores;
    w_n_donmi_nx = r_n_donmi;
    w_b_out_nx   = r_b_out;
    w_vec_nx     = r_vec;
    w_id_nx      = r_id;
    w_latch      = 1'b0;
    w_clr_res    = 1'b0;
    w_clr_nmi    = 1'b0;
    w_cls        = CLS_NONE;

    case (r_state)
      IDLE: begin
        if (bus.INT_ACK && bus.BRK_OP) w_latch = 1'b1;
        else if (bus.T0 && w_any)      w_state_nx = REQ;
      end
      REQ: begin
        if (bus.INT_ACK)           w_latch = 1'b1;
        else if (bus.T0 && !w_any) w_state_nx = IDLE;
      end
      SEQ: begin
        if (bus.VEC_DONE) begin
          w_state_nx   = IDLE;
          w_dores_nx   = 1'b0;
          w_n_donmi_nx = 1'b1;
          w_b_out_nx   = 1'b0;
        end
      end
      default: w_state_nx = IDLE;
    endcase

    // Class is chosen from the pends as they stand before this edge.
    if (w_latch) begin
      w_state_nx = SEQ;
      if (r_res_pend)      w_cls = CLS_RES;
      else if (r_nmi_pend) w_cls = CLS_NMI;
      else if (w_irq_ok)   w_cls = CLS_IRQ;
      else                 w_cls = CLS_BRK;

      case (w_cls)
        CLS_RES: begin
          w_dores_nx = 1'b1;
          w_vec_nx   = VEC_RES;
          w_clr_res  = 1'b1;
        end
        CLS_NMI: begin
          w_n_donmi_nx = 1'b0;
          w_vec_nx     = VEC_NMI;
          w_clr_nmi    = 1'b1;
        end
        CLS_IRQ: begin
          w_vec_nx = w_irq_vec;
          w_id_nx  = w_irq_idx;
        end
        default: begin
          w_b_out_nx = 1'b1;
          w_vec_nx   = VEC_IRQ;
        end
      endcase
    end
  end

  always_ff @(posedge PHI0) begin
    if (RES) begin
      r_state    <= IDLE;
      r_res_pend <= 1'b1;
      r_nmi_pend <= 1'b0;
      r_nmi_prev <= 1'b1;
      r_dores    <= 1'b0;
      r_n_donmi  <= 1'b1;
      r_b_out    <= 1'b0;
      r_vec      <= VEC_RES;
      r_id       <= '0;
    end else begin
      r_state    <= w_state_nx;
      r_nmi_prev <= w_nmi_s;
      r_res_pend <= r_res_pend & ~w_clr_res;
      if (w_clr_nmi)       r_nmi_pend <= 1'b0;
      else if (w_nmi_fall) r_nmi_pend <= 1'b1;
      r_dores    <= w_dores_nx;
      r_n_donmi  <= w_n_donmi_nx;
      r_b_out    <= w_b_out_nx;
      r_vec      <= w_vec_nx;
      r_id       <= w_id_nx;
    end
  end

  assign bus.INT_REQ  = (r_state == REQ);
  assign bus.BUSY     = (r_state == SEQ);
  assign bus.DORES    = r_dores;
  assign bus.n_DONMI  = r_n_donmi;
  assign bus.B_OUT    = r_b_out;
  assign bus.VEC_ADDR = r_vec;
  assign bus.IRQ_ID   = r_id;
endmodule

// File: tb/tb_int_sequencer.sv
// Directed bench for int_sequencer: reset, RES/IRQ/NMI/BRK sequences, masking and abort.
module tb_int_sequencer;
  logic PHI0 = 1'b0;
  logic RES;
  int   checks = 0;
  int   errors = 0;

`ifdef INT_SEQ_VECTORED_IRQ_EN
  localparam logic [15:0] EXP_IRQ0 = 16'hFFE0;
  localparam logic [15:0] EXP_IRQ2 = 16'hFFE4;
`else
  localparam logic [15:0] EXP_IRQ0 = 16'hFFFE;
  localparam logic [15:0] EXP_IRQ2 = 16'hFFFE;
`endif

  int_sequencer_if #(.N_IRQ(4)) bus ();

  int_sequencer #(.N_IRQ(4), .SYNC_STAGES(2), .IRQ_VEC_BASE(16'hFFE0)) dut (
    .PHI0(PHI0), .RES(RES), .bus(bus)
  );

  always #5 PHI0 = ~PHI0;

  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge PHI0);
      #1;
    end
  endtask

  task automatic pulse_t0();
    bus.T0 = 1'b1; tick(); bus.T0 = 1'b0;
  endtask

  task automatic pulse_ack();
    bus.INT_ACK = 1'b1; tick(); bus.INT_ACK = 1'b0;
  endtask

  task automatic pulse_done();
    bus.VEC_DONE = 1'b1; tick(); bus.VEC_DONE = 1'b0;
  endtask

  task automatic test_reset();
    RES = 1'b1; tick(2);
    checks++; if (bus.INT_REQ !== 1'b0) begin errors++; $display("FAIL rst_req got %b want 0", bus.INT_REQ); end
    checks++; if (bus.DORES !== 1'b0) begin errors++; $display("FAIL rst_dores got %b want 0", bus.DORES); end
    checks++; if (bus.n_DONMI !== 1'b1) begin errors++; $display("FAIL rst_ndonmi got %b want 1", bus.n_DONMI); end
    checks++; if (bus.VEC_ADDR !== 16'hFFFC) begin errors++; $display("FAIL rst_vec got %h want fffc", bus.VEC_ADDR); end
    checks++; if (bus.BUSY !== 1'b0) begin errors++; $display("FAIL rst_busy got %b want 0", bus.BUSY); end
    RES = 1'b0; tick();
    pulse_t0();
    checks++; if (bus.INT_REQ !== 1'b1) begin errors++; $display("FAIL por_req got %b want 1", bus.INT_REQ); end
    pulse_ack();
    checks++; if (bus.DORES !== 1'b1) begin errors++; $display("FAIL por_dores got %b want 1", bus.DORES); end
    checks++; if (bus.VEC_ADDR !== 16'hFFFC) begin errors++; $display("FAIL por_vec got %h want fffc", bus.VEC_ADDR); end
    checks++; if (bus.BUSY !== 1'b1 || bus.INT_REQ !== 1'b0) begin errors++; $display("FAIL por_busy got busy=%b req=%b want 1/0", bus.BUSY, bus.INT_REQ); end
    pulse_done();
    checks++; if (bus.DORES !== 1'b0 || bus.BUSY !== 1'b0) begin errors++; $display("FAIL por_done got dores=%b busy=%b want 0/0", bus.DORES, bus.BUSY); end
  endtask

  task automatic test_irq_priority();
    bus.n_IRQ = 4'b1010; bus.IRQ_EN = 4'hF; tick(3);
    pulse_t0();
    checks++; if (bus.INT_REQ !== 1'b1) begin errors++; $display("FAIL irq_req got %b want 1", bus.INT_REQ); end
    pulse_ack();
    checks++; if (bus.IRQ_ID !== 2'd0) begin errors++; $display("FAIL irq_id0 got %0d want 0", bus.IRQ_ID); end
    checks++; if (bus.VEC_ADDR !== EXP_IRQ0) begin errors++; $display("FAIL irq_vec0 got %h want %h", bus.VEC_ADDR, EXP_IRQ0); end
    pulse_done();
    bus.IRQ_EN = 4'hE;
    pulse_t0(); pulse_ack();
    checks++; if (bus.IRQ_ID !== 2'd2) begin errors++; $display("FAIL irq_id2 got %0d want 2", bus.IRQ_ID); end
    checks++; if (bus.VEC_ADDR !== EXP_IRQ2) begin errors++; $display("FAIL irq_vec2 got %h want %h", bus.VEC_ADDR, EXP_IRQ2); end
  endtask

  task automatic test_nmi_during_seq();
    bus.n_NMI = 1'b0; tick(4);
    checks++; if (bus.BUSY !== 1'b1 || bus.n_DONMI !== 1'b1) begin errors++; $display("FAIL nmi_hold got busy=%b ndonmi=%b want 1/1", bus.BUSY, bus.n_DONMI); end
    checks++; if (bus.VEC_ADDR !== EXP_IRQ2) begin errors++; $display("FAIL nmi_hold_vec got %h want %h", bus.VEC_ADDR, EXP_IRQ2); end
    pulse_done();
    bus.n_IRQ = 4'hF; tick(3);
    checks++; if (bus.INT_REQ !== 1'b0) begin errors++; $display("FAIL nmi_noT0 got %b want 0", bus.INT_REQ); end
    pulse_t0();
    checks++; if (bus.INT_REQ !== 1'b1) begin errors++; $display("FAIL nmi_req got %b want 1", bus.INT_REQ); end
    pulse_ack();
    checks++; if (bus.n_DONMI !== 1'b0) begin errors++; $display("FAIL nmi_ndonmi got %b want 0", bus.n_DONMI); end
    checks++; if (bus.VEC_ADDR !== 16'hFFFA) begin errors++; $display("FAIL nmi_vec got %h want fffa", bus.VEC_ADDR); end
    checks++; if (bus.IRQ_ID !== 2'd2) begin errors++; $display("FAIL nmi_id_hold got %0d want 2", bus.IRQ_ID); end
    pulse_done();
    checks++; if (bus.n_DONMI !== 1'b1) begin errors++; $display("FAIL nmi_done got %b want 1", bus.n_DONMI); end
    bus.n_NMI = 1'b1; tick(3);
  endtask

  task automatic test_mask_and_drop();
    bus.IRQ_EN = 4'hF; bus.I_FLAG = 1'b1; bus.n_IRQ = 4'b1110; tick(3);
    pulse_t0();
    checks++; if (bus.INT_REQ !== 1'b0) begin errors++; $display("FAIL mask_req got %b want 0", bus.INT_REQ); end
    bus.I_FLAG = 1'b0;
    pulse_t0();
    checks++; if (bus.INT_REQ !== 1'b1) begin errors++; $display("FAIL unmask_req got %b want 1", bus.INT_REQ); end
    bus.n_IRQ = 4'hF; tick(3);
    checks++; if (bus.INT_REQ !== 1'b1) begin errors++; $display("FAIL drop_hold got %b want 1", bus.INT_REQ); end
    pulse_t0();
    checks++; if (bus.INT_REQ !== 1'b0 || bus.BUSY !== 1'b0) begin errors++; $display("FAIL drop_idle got req=%b busy=%b want 0/0", bus.INT_REQ, bus.BUSY); end
    pulse_ack();
    checks++; if (bus.BUSY !== 1'b0) begin errors++; $display("FAIL ack_ignored got %b want 0", bus.BUSY); end
  endtask

  task automatic test_brk();
    bus.BRK_OP = 1'b1; pulse_ack();
    checks++; if (bus.B_OUT !== 1'b1 || bus.BUSY !== 1'b1) begin errors++; $display("FAIL brk_bout got bout=%b busy=%b want 1/1", bus.B_OUT, bus.BUSY); end
    checks++; if (bus.VEC_ADDR !== 16'hFFFE) begin errors++; $display("FAIL brk_vec got %h want fffe", bus.VEC_ADDR); end
    pulse_ack();
    checks++; if (bus.B_OUT !== 1'b1 || bus.BUSY !== 1'b1) begin errors++; $display("FAIL brk_seq_ack got bout=%b busy=%b want 1/1", bus.B_OUT, bus.BUSY); end
    bus.BRK_OP = 1'b0;
    pulse_done();
    checks++; if (bus.B_OUT !== 1'b0 || bus.VEC_ADDR !== 16'hFFFE) begin errors++; $display("FAIL brk_done got bout=%b vec=%h want 0/fffe", bus.B_OUT, bus.VEC_ADDR); end
    // NMI pend-set lands on the ACK edge: this BRK must not take it.
    bus.n_NMI = 1'b0; tick(2);
    bus.BRK_OP = 1'b1; pulse_ack(); bus.BRK_OP = 1'b0;
    checks++; if (bus.B_OUT !== 1'b1 || bus.n_DONMI !== 1'b1) begin errors++; $display("FAIL coll_brk got bout=%b ndonmi=%b want 1/1", bus.B_OUT, bus.n_DONMI); end
    pulse_done();
    bus.BRK_OP = 1'b1; pulse_ack(); bus.BRK_OP = 1'b0;
    checks++; if (bus.n_DONMI !== 1'b0 || bus.B_OUT !== 1'b0) begin errors++; $display("FAIL brk_nmi got ndonmi=%b bout=%b want 0/0", bus.n_DONMI, bus.B_OUT); end
    checks++; if (bus.VEC_ADDR !== 16'hFFFA) begin errors++; $display("FAIL brk_nmi_vec got %h want fffa", bus.VEC_ADDR); end
    pulse_done();
    bus.n_NMI = 1'b1; tick(3);
  endtask

  task automatic test_reset_mid_seq();
    bus.n_IRQ = 4'b1011; bus.IRQ_EN = 4'hF; tick(3);
    pulse_t0(); pulse_ack();
    checks++; if (bus.IRQ_ID !== 2'd2 || bus.BUSY !== 1'b1) begin errors++; $display("FAIL pre_abort got id=%0d busy=%b want 2/1", bus.IRQ_ID, bus.BUSY); end
    RES = 1'b1; tick(); RES = 1'b0;
    checks++; if (bus.BUSY !== 1'b0 || bus.IRQ_ID !== 2'd0) begin errors++; $display("FAIL abort_state got busy=%b id=%0d want 0/0", bus.BUSY, bus.IRQ_ID); end
    checks++; if (bus.VEC_ADDR !== 16'hFFFC || bus.INT_REQ !== 1'b0) begin errors++; $display("FAIL abort_vec got vec=%h req=%b want fffc/0", bus.VEC_ADDR, bus.INT_REQ); end
    bus.n_IRQ = 4'hF;
    pulse_t0();
    checks++; if (bus.INT_REQ !== 1'b1) begin errors++; $display("FAIL abort_req got %b want 1", bus.INT_REQ); end
    pulse_ack();
    checks++; if (bus.DORES !== 1'b1 || bus.VEC_ADDR !== 16'hFFFC) begin errors++; $display("FAIL abort_res got dores=%b vec=%h want 1/fffc", bus.DORES, bus.VEC_ADDR); end
    pulse_done();
  endtask

  initial begin
    RES = 1'b1;
    bus.n_NMI = 1'b1; bus.n_IRQ = 4'hF; bus.IRQ_EN = 4'hF; bus.I_FLAG = 1'b0;
    bus.T0 = 1'b0; bus.BRK_OP = 1'b0; bus.INT_ACK = 1'b0; bus.VEC_DONE = 1'b0;
    test_reset();
    test_irq_priority();
    test_nmi_during_seq();
    test_mask_and_drop();
    test_brk();
    test_reset_mid_seq();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/int_sequencer.md
Name: int_sequencer

Overview:
Parametrised interrupt sequencer for the 6502 core family. It generalises the fixed RES/NMI/IRQ/BRK handling to N_IRQ maskable sources with fixed priority, edge-latched NMI and a per-source in-service ID. The block sits between the pads and the dispatch/BRK logic. It requests an interrupt sequence at instruction boundaries, latches the winning class when the core acknowledges, and supplies the 16-bit vector plus the DORES, DONMI and B_OUT qualifiers until the vector fetch completes.

Parameters:
N_IRQ, 4, number of maskable interrupt sources (1..16)
SYNC_STAGES, 2, flop depth of the input synchronisers on n_NMI and n_IRQ (>=1)
IRQ_VEC_BASE, 16'hFFE0, base address for per-source vectors (used only with the optional feature)

Ports:
PHI0  in  1  reference clock; the only clock
RES  in  1  synchronous reset, active-high
n_NMI  in  1  non-maskable interrupt, active low, asynchronous
n_IRQ  in  N_IRQ  maskable interrupt sources, active low, level, asynchronous
IRQ_EN  in  N_IRQ  per-source enable, 1 = enabled
I_FLAG  in  1  CPU interrupt-disable flag
T0  in  1  instruction-boundary strobe, one PHI0 cycle
BRK_OP  in  1  software BRK is executing
INT_ACK  in  1  core starts the interrupt sequence (BRK5 point)
VEC_DONE  in  1  core has fetched the vector high byte (BRK7 point)
INT_REQ  out  1  interrupt sequence requested
DORES  out  1  current sequence is reset
n_DONMI  out  1  0 = current sequence is NMI
B_OUT  out  1  1 = current sequence is software BRK
VEC_ADDR  out  16  vector address (low byte address; high = +1)
IRQ_ID  out  clog2(N_IRQ) max 1  index of the IRQ being serviced
BUSY  out  1  sequence in progress

Behaviour:
- Reset (RES=1 at PHI0 edge): state=IDLE; res_pend=1, nmi_pend=0; synchronisers load 1 (inactive); INT_REQ=0, DORES=0, n_DONMI=1, B_OUT=0, VEC_ADDR=16'hFFFC, IRQ_ID=0, BUSY=0. RES mid-sequence aborts to the same values.
- Inputs pass through SYNC_STAGES flops. An NMI falling edge (synced previous=1, current=0) sets nmi_pend on the following edge. Extra edges while pending are absorbed.
- irq_ok = |(~n_IRQ_sync & IRQ_EN) & ~I_FLAG.
- States: IDLE, REQ, SEQ.
- IDLE -> REQ on an edge where T0=1 and (res_pend | nmi_pend | irq_ok). INT_REQ=1 from the next cycle.
- In REQ, INT_REQ is re-evaluated at every T0. If no source remains (IRQ deasserted or masked, no pend), the block returns to IDLE and INT_REQ drops.
- INT_ACK accepted in REQ, or in IDLE when BRK_OP=1. On that edge the block latches its class by priority RES > NMI > IRQ > BRK:
  - RES: DORES=1, VEC_ADDR=FFFC, res_pend cleared.
  - NMI: n_DONMI=0, VEC_ADDR=FFFA, nmi_pend cleared.
  - IRQ: VEC_ADDR=FFFE, IRQ_ID=lowest active enabled index.
  - BRK: B_OUT=1, VEC_ADDR=FFFE.
  - After latching: state=SEQ, INT_REQ=0, BUSY=1.
- INT_ACK in SEQ, or in IDLE without BRK_OP, is ignored.
- Outputs hold stable throughout SEQ. On VEC_DONE in SEQ the block returns to IDLE: DORES=0, n_DONMI=1, B_OUT=0, BUSY=0. VEC_ADDR and IRQ_ID hold their last values. VEC_DONE outside SEQ is ignored.
- An NMI edge whose pend-set lands on the same edge as INT_ACK is not part of that latch. It is served by the next sequence.
- An NMI arriving during SEQ stays pending. An IRQ is never latched, so an IRQ that drops before INT_ACK is lost.
- A BRK in SEQ is ignored.

Optional Feature:
Macro INT_SEQ_VECTORED_IRQ_EN.
- Defined: the IRQ class uses VEC_ADDR = IRQ_VEC_BASE + 2*IRQ_ID. BRK keeps FFFE.
- Undefined: all IRQs share FFFE. IRQ_ID is still reported and the IRQ_VEC_BASE parameter is unused.

Decomposition:
- Package core6502_int_pkg holds the class enum (CLS_NONE, CLS_RES, CLS_NMI, CLS_IRQ, CLS_BRK), the state enum (IDLE, REQ, SEQ) and the vector constants VEC_NMI=FFFA, VEC_RES=FFFC, VEC_IRQ=FFFE.
- One sub-module, int_sync, is a parametrised-width, SYNC_STAGES-deep synchroniser with reset value 1. It is instantiated for n_NMI and for n_IRQ.

Test Plan:
- Power-on: RES=1 for 2 cycles then 0, T0 pulse -> INT_REQ=1; INT_ACK -> DORES=1, VEC_ADDR=FFFC, BUSY=1; VEC_DONE -> DORES=0, BUSY=0.
- n_IRQ=4'b1010, IRQ_EN=4'hF, I_FLAG=0, T0, INT_ACK -> IRQ_ID=0, VEC_ADDR=FFFE (FFE0 with the macro); with IRQ_EN=4'hE -> IRQ_ID=2 (FFE4 with the macro).
- NMI falling edge during an IRQ sequence -> no effect until VEC_DONE; next T0 -> INT_REQ=1; INT_ACK -> n_DONMI=0, VEC_ADDR=FFFA.
- I_FLAG=1 with IRQ asserted at T0 -> INT_REQ stays 0. IRQ asserted then released before the next T0 -> INT_REQ falls, state IDLE.
- BRK_OP=1, INT_ACK with no source pending -> B_OUT=1, VEC_ADDR=FFFE. Repeat with nmi_pend=1 -> n_DONMI=0, B_OUT=0, VEC_ADDR=FFFA.
- RES asserted mid-SEQ -> all outputs at reset values next cycle; next T0 -> INT_REQ=1 with the RES class.
